piece_scheduler: RTL and testbench
==================================

Name: piece_scheduler

Overview:
- Deals Tetris piece IDs to the game FSM using a 7-bag randomizer.
- Samples the free-running LFSR value every clock.
- Rejects out-of-range or already-dealt IDs.
- Keeps a small look-ahead queue so the "next piece" preview is always populated.
- Sits between the LFSR and the game-control/VGA preview logic.

Parameters:
- NUM_PIECES, 7, distinct piece IDs 0..NUM_PIECES-1; bag width.
- PREVIEW_DEPTH, 3, preview slots exposed behind the current piece; queue depth Q = PREVIEW_DEPTH+1.
- RAND_W, 8, width of the rand_in sample.
- RETRY_LIMIT, 4, consecutive rejections before the deterministic fallback draw.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse: new game; flush and refill.
- rand_in  input  RAND_W  LFSR output, sampled every cycle; only bits [2:0] used.
- piece_req  input  1  game FSM consumes the current piece.
- piece_valid  output  1  piece_id is valid.
- piece_id  output  3  current (head) piece.
- preview_ids  output  3*PREVIEW_DEPTH  queue entries 1..PREVIEW_DEPTH; slot k at bits [3k+2:3k]; empty slot = 3'b111.
- preview_count  output  3  valid preview slots, 0..PREVIEW_DEPTH.
- underflow_err  output  1  sticky: piece_req seen while piece_valid=0.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; bag=all ones (7'h7F); queue empty; retry counter=0.
  - Outputs: piece_valid=0, piece_id=0, preview_ids all 3'b111, preview_count=0, underflow_err=0.
  - Reset asserted mid-FILL aborts immediately with no partial push.
- States:
  - IDLE: no draws; all requests ignored except underflow flagging. start -> FILL.
  - FILL: queue count < Q; one draw attempt per cycle. Count reaches Q -> READY.
  - READY: queue full; no draws. Pop -> FILL.
- start, from any state including mid-FILL or READY:
  - Same edge: queue cleared, bag=7'h7F, retry=0, underflow_err cleared, next state FILL.
  - start wins over a simultaneous piece_req; the pop is discarded.
- Draw attempt (FILL only):
  - cand = rand_in[2:0].
  - Accept if cand < NUM_PIECES and bag[cand]=1: push cand at tail, clear bag[cand], retry=0.
  - Otherwise reject: retry increments.
  - When retry = RETRY_LIMIT, the draw in that cycle takes the lowest-index set bag bit instead, then retry=0. A draw therefore always completes within RETRY_LIMIT+1 cycles.
  - Bag becomes zero after a push: refilled to 7'h7F on the same edge. Each consecutive group of 7 dealt pieces is a permutation of 0..6.
- Pop:
  - Occurs when piece_req=1 and piece_valid=1; head advances on that edge.
  - Simultaneous pop and push: both occur, count unchanged, order preserved (push lands behind remaining entries).
  - piece_req with piece_valid=0: no state change, underflow_err<=1.
- Outputs:
  - piece_valid = count>0.
  - piece_id = head entry, or 0 when empty.
  - preview_count = max(count-1, 0).
- Latency:
  - start at edge N -> earliest piece_valid=1 after edge N+1.
  - Queue full at edge N+Q at best.

Optional Feature:
- Macro: PIECE_SCHEDULER_STATS_EN.
- When defined:
  - Adds output dealt_count[15:0]: increments on every pop, wraps 16'hFFFF -> 0.
  - Clears on reset and on start.
  - Adds output fallback_count[7:0]: increments on each fallback draw and saturates at 8'hFF.
- When undefined: neither port nor its counters exist; all other behaviour is identical.

Test Plan:
- Reset: resetn=0 mid-FILL for 1 cycle -> piece_valid=0, preview_count=0, preview_ids=9'h1FF, underflow_err=0; no draws until start.
- Reject rules: start, then rand_in low bits 3,3,7,5,0,6 -> queue holds 3,5,0,6; piece_id=3; preview slots 5,0,6; piece_valid at cycle 2 after start.
- Bag completeness: start, rand_in low bits cycling 0..7, pop whenever valid for 14 pops -> pops 1-7 are a permutation of 0..6, pops 8-14 likewise; no ID repeats within a bag.
- Fallback: rand_in[2:0] held at 7 -> one piece every RETRY_LIMIT+1=5 cycles, in order 0,1,2,3; with stats enabled, fallback_count=4.
- Simultaneous pop/push plus underflow: in FILL with count=2, piece_req=1 on a cycle with accepted draw -> count stays 2, order preserved. Separately, piece_req in IDLE -> underflow_err=1 and stays 1 until start.
- start mid-operation: in READY with start and piece_req both high -> next cycle piece_valid=0, bag=7'h7F, underflow_err=0, state FILL; dealt_count=0 with stats enabled.

Source files
------------

// File: rtl/piece_scheduler.sv
// piece_scheduler: deals Tetris piece IDs using a 7-bag randomizer.
//
// The free-running LFSR value is sampled every cycle. IDs that are out of range
// or already dealt from the current bag are rejected. A small look-ahead queue
// keeps the "next piece" preview populated.
//
// Ports:
//   clock          system clock, rising-edge
//   resetn         asynchronous active-low reset
//   start          one-cycle new-game pulse: flush the queue and refill it
//   rand_in        LFSR sample; only bits [2:0] are used
//   piece_req      game FSM consumes the current (head) piece
//   piece_valid    the queue is non-empty
//   piece_id       head piece, or 0 when the queue is empty
//   preview_ids    queue entries 1..PREVIEW_DEPTH; slot k at [3k+2:3k]; empty = 3'b111
//   preview_count  number of valid preview slots
//   underflow_err  sticky: piece_req seen while piece_valid was 0
//
// Optional build macro PIECE_SCHEDULER_STATS_EN adds two outputs:
//   dealt_count    16-bit wrapping count of pops
//   fallback_count 8-bit saturating count of fallback draws
module piece_scheduler #(
    parameter int unsigned NUM_PIECES    = 7,
    parameter int unsigned PREVIEW_DEPTH = 3,
    parameter int unsigned RAND_W        = 8,
    parameter int unsigned RETRY_LIMIT   = 4
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       start,
    input  logic [RAND_W-1:0]          rand_in,
    input  logic                       piece_req,
    output logic                       piece_valid,
    output logic [2:0]                 piece_id,
    output logic [3*PREVIEW_DEPTH-1:0] preview_ids,
    output logic [2:0]                 preview_count,
    output logic                       underflow_err
`ifdef PIECE_SCHEDULER_STATS_EN
    ,
    output logic [15:0]                dealt_count,
    output logic [7:0]                 fallback_count
`endif
);

    localparam int unsigned Q       = PREVIEW_DEPTH + 1;
    localparam int unsigned CNT_W   = $clog2(Q + 1);
    localparam int unsigned RETRY_W = $clog2(RETRY_LIMIT + 1);

    typedef enum logic [1:0] {StIdle, StFill, StReady} state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [2:0]             r_q [Q];
    logic [2:0]             w_q_next [Q];
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_next;
    logic [NUM_PIECES-1:0]  r_bag;
    logic [NUM_PIECES-1:0]  w_bag_next;
    logic [NUM_PIECES-1:0]  w_bag_clr;
    logic [RETRY_W-1:0]     r_retry;
    logic [RETRY_W-1:0]     w_retry_next;
    logic                   r_uf;
    logic                   w_uf_next;

    logic [2:0]             w_cand;
    logic                   w_hit;
    logic [2:0]             w_low;
    logic                   w_draw;
    logic                   w_fallback;
    logic                   w_push;
    logic [2:0]             w_push_id;
    logic [CNT_W-1:0]       w_push_idx;
    logic                   w_pop;
    logic                   w_unused_rand;

    assign w_cand        = rand_in[2:0];
    assign w_unused_rand = ^rand_in[RAND_W-1:3];

    // Draw decision: a direct hit on a remaining bag ID, or the forced
    // lowest-remaining ID once the retry budget is spent.
    always_comb begin
        w_hit = 1'b0;
        w_low = '0;
        for (int i = 0; i < int'(NUM_PIECES); i++) begin
            if (w_cand == 3'(i) && r_bag[i]) begin
                w_hit = 1'b1;
            end
        end
        for (int i = int'(NUM_PIECES) - 1; i >= 0; i--) begin
            if (r_bag[i]) begin
                w_low = 3'(i);
            end
        end
        w_pop      = piece_req && (r_count != '0);
        w_draw     = (r_state == StFill);
        w_fallback = w_draw && (r_retry == RETRY_W'(RETRY_LIMIT));
        w_push     = w_draw && (w_fallback || w_hit);
        w_push_id  = w_fallback ? w_low : w_cand;
        // On a simultaneous pop the push lands one slot lower, behind the survivors.
        w_push_idx = r_count - CNT_W'(w_pop);
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_next = r_state;
        w_q_next     = r_q;
        w_count_next = r_count;
        w_bag_next   = r_bag;
        w_bag_clr    = r_bag;
        w_retry_next = r_retry;
        w_uf_next    = r_uf;

        if (start) begin
            w_state_next = StFill;
            w_count_next = '0;
            w_bag_next   = '1;
            w_retry_next = '0;
            w_uf_next    = 1'b0;
        end else begin
            if (piece_req && !w_pop) begin
                w_uf_next = 1'b1;
            end

            if (w_pop) begin
                for (int i = 0; i < int'(Q) - 1; i++) begin
                    w_q_next[i] = r_q[i+1];
                end
            end

            if (w_push) begin
                for (int i = 0; i < int'(Q); i++) begin
                    if (CNT_W'(i) == w_push_idx) begin
                        w_q_next[i] = w_push_id;
                    end
                end
                for (int i = 0; i < int'(NUM_PIECES); i++) begin
                    if (w_push_id == 3'(i)) begin
                        w_bag_clr[i] = 1'b0;
                    end
                end
                // Last ID of a bag dealt: start the next bag on the same edge.
                w_bag_next = (w_bag_clr == '0) ? '1 : w_bag_clr;
            end

            w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

            if (w_draw) begin
                w_retry_next = w_push ? '0 : r_retry + RETRY_W'(1);
            end

            unique case (r_state)
                StIdle:  w_state_next = StIdle;
                StFill:  w_state_next = (w_count_next == CNT_W'(Q)) ? StReady : StFill;
                StReady: w_state_next = w_pop ? StFill : StReady;
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
            r_q     <= '{default: '0};
            r_count <= '0;
            r_bag   <= '1;
            r_retry <= '0;
            r_uf    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_q     <= w_q_next;
            r_count <= w_count_next;
            r_bag   <= w_bag_next;
            r_retry <= w_retry_next;
            r_uf    <= w_uf_next;
        end
    end

    // Outputs are derived from the queue occupancy.
    always_comb begin
        piece_valid   = (r_count != '0);
        piece_id      = piece_valid ? r_q[0] : 3'd0;
        preview_count = (r_count == '0) ? 3'd0 : 3'(r_count - CNT_W'(1));
        underflow_err = r_uf;
        preview_ids   = '1;
        for (int k = 0; k < int'(PREVIEW_DEPTH); k++) begin
            if (CNT_W'(k + 1) < r_count) begin
                preview_ids[3*k +: 3] = r_q[k+1];
            end
        end
    end

`ifdef PIECE_SCHEDULER_STATS_EN
    logic [15:0] r_dealt;
    logic [7:0]  r_fb;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_dealt <= '0;
            r_fb    <= '0;
        end else if (start) begin
            r_dealt <= '0;
            r_fb    <= '0;
        end else begin
            if (w_pop) begin
                r_dealt <= r_dealt + 16'd1;
            end
            if (w_fallback && (r_fb != 8'hFF)) begin
                r_fb <= r_fb + 8'd1;
            end
        end
    end

    assign dealt_count    = r_dealt;
    assign fallback_count = r_fb;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_piece_scheduler.sv
// Self-checking bench for piece_scheduler: directed scenarios followed by a
// randomized phase, all checked against a queue/bag reference model.
module tb_piece_scheduler;

    localparam int NP = 7;
    localparam int PD = 3;
    localparam int Q  = PD + 1;
    localparam int RL = 4;

    logic         clock;
    logic         resetn;
    logic         start;
    logic [7:0]   rand_in;
    logic         piece_req;
    logic         piece_valid;
    logic [2:0]   piece_id;
    logic [8:0]   preview_ids;
    logic [2:0]   preview_count;
    logic         underflow_err;
`ifdef PIECE_SCHEDULER_STATS_EN
    logic [15:0]  dealt_count;
    logic [7:0]   fallback_count;
`endif

    piece_scheduler dut (
        .clock         (clock),
        .resetn        (resetn),
        .start         (start),
        .rand_in       (rand_in),
        .piece_req     (piece_req),
        .piece_valid   (piece_valid),
        .piece_id      (piece_id),
        .preview_ids   (preview_ids),
        .preview_count (preview_count),
        .underflow_err (underflow_err)
`ifdef PIECE_SCHEDULER_STATS_EN
        ,
        .dealt_count   (dealt_count),
        .fallback_count(fallback_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the queue of dealt-but-unconsumed IDs and the set of
    // IDs still left in the current bag.
    int m_q[$];
    bit m_in_bag[NP];
    int m_retry;
    bit m_uf;
    bit m_run;
    int m_dealt;
    int m_fb;

    int obs_pops[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        for (int i = 0; i < NP; i++) m_in_bag[i] = 1'b1;
        m_retry = 0;
        m_uf    = 1'b0;
        m_run   = 1'b0;
        m_dealt = 0;
        m_fb    = 0;
    endfunction

    function automatic void model_step(input bit s, input logic [7:0] r, input bit req);
        bit do_pop;
        bit do_push;
        bit any_left;
        int cand;
        int id;
        if (s) begin
            model_reset();
            m_run = 1'b1;
            return;
        end
        do_pop  = req && (m_q.size() > 0);
        do_push = 1'b0;
        id      = 0;
        if (req && m_q.size() == 0) m_uf = 1'b1;
        if (m_run && m_q.size() < Q) begin
            cand = int'(r[2:0]);
            if (m_retry == RL) begin
                for (int i = 0; i < NP; i++) begin
                    if (m_in_bag[i]) begin
                        id = i;
                        break;
                    end
                end
                do_push = 1'b1;
                if (m_fb < 255) m_fb++;
            end else if (cand < NP && m_in_bag[cand]) begin
                id      = cand;
                do_push = 1'b1;
            end
            m_retry = do_push ? 0 : m_retry + 1;
        end
        if (do_pop) begin
            void'(m_q.pop_front());
            m_dealt = (m_dealt + 1) % 65536;
        end
        if (do_push) begin
            m_q.push_back(id);
            m_in_bag[id] = 1'b0;
            any_left = 1'b0;
            for (int i = 0; i < NP; i++) any_left |= m_in_bag[i];
            if (!any_left) for (int i = 0; i < NP; i++) m_in_bag[i] = 1'b1;
        end
    endfunction

    task automatic check_all(input string tag);
        logic [8:0] exp_prev;
        int n;
        n = m_q.size();
        exp_prev = '1;
        for (int k = 0; k < PD; k++) begin
            if (k + 1 < n) exp_prev[3*k +: 3] = 3'(m_q[k+1]);
        end
        chk({tag, ".valid"}, 32'(piece_valid), 32'(n > 0));
        chk({tag, ".id"}, 32'(piece_id), (n > 0) ? 32'(m_q[0]) : 32'd0);
        chk({tag, ".preview"}, 32'(preview_ids), 32'(exp_prev));
        chk({tag, ".pcount"}, 32'(preview_count), (n > 0) ? 32'(n - 1) : 32'd0);
        chk({tag, ".uf"}, 32'(underflow_err), 32'(m_uf));
`ifdef PIECE_SCHEDULER_STATS_EN
        chk({tag, ".dealt"}, 32'(dealt_count), 32'(m_dealt));
        chk({tag, ".fb"}, 32'(fallback_count), 32'(m_fb));
`endif
    endtask

    // One clock: drive at the negedge, update the model at the posedge, check 1 time unit later.
    task automatic step(input string tag, input bit s, input logic [7:0] r, input bit req);
        start     = s;
        rand_in   = r;
        piece_req = req;
        if (req && !s && piece_valid) obs_pops.push_back(int'(piece_id));
        @(posedge clock);
        model_step(s, r, req);
        #1;
        check_all(tag);
        @(negedge clock);
    endtask

    // Rand value with the given low bits and random upper bits.
    function automatic logic [7:0] rv(input int low);
        logic [7:0] v;
        v = 8'($urandom);
        v[2:0] = 3'(low);
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int mask;
        int guard;
        logic [7:0] seq [6];

        resetn    = 1'b0;
        start     = 1'b0;
        rand_in   = '0;
        piece_req = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        check_all("reset");
        chk("reset_preview", 32'(preview_ids), 32'h1FF);
        resetn = 1'b1;
        @(negedge clock);

        // Rejection of out-of-range and already-dealt IDs.
        seq[0] = rv(3); seq[1] = rv(3); seq[2] = rv(7);
        seq[3] = rv(5); seq[4] = rv(0); seq[5] = rv(6);
        step("rej_start", 1, rv(2), 0);
        chk("rej_valid_c1", 32'(piece_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step("rej", 0, seq[i], 0);
            if (i == 0) chk("rej_valid_c2", 32'(piece_valid), 32'd1);
        end
        chk("rej_head", 32'(piece_id), 32'd3);
        chk("rej_preview", 32'(preview_ids), 32'h185);
        chk("rej_pcount", 32'(preview_count), 32'd3);
        step("ready_hold", 0, rv(1), 0);
        chk("ready_hold_head", 32'(piece_id), 32'd3);

        // Asynchronous reset in the middle of a fill.
        step("mid_start", 1, rv(0), 0);
        step("mid_fill", 0, rv(1), 0);
        step("mid_fill", 0, rv(2), 0);
        resetn = 1'b0;
        #2;
        model_reset();
        chk("arst_valid", 32'(piece_valid), 32'd0);
        chk("arst_pcount", 32'(preview_count), 32'd0);
        chk("arst_preview", 32'(preview_ids), 32'h1FF);
        chk("arst_uf", 32'(underflow_err), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) step("idle_nodraw", 0, 8'($urandom), 0);
        chk("idle_nodraw_valid", 32'(piece_valid), 32'd0);

        // Underflow in IDLE is sticky until start.
        step("uf_req", 0, rv(1), 1);
        chk("uf_set", 32'(underflow_err), 32'd1);
        for (int i = 0; i < 3; i++) step("uf_hold", 0, rv(i), 0);
        chk("uf_sticky", 32'(underflow_err), 32'd1);
        step("uf_clear", 1, rv(0), 0);
        chk("uf_cleared", 32'(underflow_err), 32'd0);

        // Bag completeness: 14 pops form two permutations of 0..6.
        obs_pops.delete();
        guard = 0;
        while (obs_pops.size() < 14 && guard < 300) begin
            step("bag", 0, rv(guard % 8), m_q.size() > 0);
            guard++;
        end
        chk("bag_pop_count", 32'(obs_pops.size()), 32'd14);
        for (int g = 0; g < 2; g++) begin
            mask = 0;
            for (int j = 0; j < 7; j++) begin
                if (7 * g + j < obs_pops.size()) mask |= (1 << obs_pops[7*g+j]);
            end
            chk("bag_permutation", 32'(mask), 32'h7F);
        end

        // Fallback draw with rand_in[2:0] stuck at 7.
        step("fb_start", 1, rv(7), 0);
        for (int i = 1; i <= 20; i++) begin
            step("fb", 0, rv(7), 0);
            if (i == 4) chk("fb_not_yet", 32'(piece_valid), 32'd0);
            if (i == 5) chk("fb_first", 32'(piece_valid), 32'd1);
        end
        chk("fb_head", 32'(piece_id), 32'd0);
        chk("fb_preview", 32'(preview_ids), 32'h0D1);
`ifdef PIECE_SCHEDULER_STATS_EN
        chk("fb_count", 32'(fallback_count), 32'd4);
`endif

        // Simultaneous pop and push keeps count and order.
        step("pp_start", 1, rv(0), 0);
        step("pp_fill", 0, rv(0), 0);
        step("pp_fill", 0, rv(1), 0);
        step("pp_both", 0, rv(2), 1);
        chk("pp_head", 32'(piece_id), 32'd1);
        chk("pp_preview", 32'(preview_ids), 32'h1FA);
        chk("pp_pcount", 32'(preview_count), 32'd1);

        // start wins over piece_req in READY.
        step("sm_start", 1, rv(7), 0);
        step("sm_uf", 0, rv(7), 1);
        for (int i = 0; i < 12; i++) step("sm_fill", 0, rv(i % 7), 0);
        chk("sm_ready", 32'(preview_count), 32'd3);
        step("sm_pop", 0, rv(7), 1);
        step("sm_refill", 0, rv(6), 0);
        step("sm_both", 1, rv(0), 1);
        chk("sm_valid", 32'(piece_valid), 32'd0);
        chk("sm_uf_clr", 32'(underflow_err), 32'd0);
`ifdef PIECE_SCHEDULER_STATS_EN
        chk("sm_dealt", 32'(dealt_count), 32'd0);
`endif
        step("sm_after", 0, rv(5), 0);
        step("sm_after", 0, rv(0), 0);
        chk("sm_head", 32'(piece_id), 32'd5);
        chk("sm_bag_full", 32'(preview_ids), 32'h1F8);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            step("rand", $urandom_range(0, 49) == 0, 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
